// File: rtl/sram_ctrl_sync.sv
// Single-outstanding controller turning arbiter requests into timed async-SRAM accesses.
// Accept -> ack next cycle; read data WAIT+1 cycles after ack; writes add one recovery cycle.
module sram_ctrl_sync #(
    parameter int AN   = 16,
    parameter int DN   = 8,
    parameter int N    = 2,
    parameter int WAIT = 2
) (
    input  logic          clkSYS,
    input  logic          n_reset,
    input  logic          i_req,
    input  logic [AN-1:0] i_addr,
    input  logic [DN-1:0] i_wdata,
    input  logic          i_wr,
    input  logic [N-1:0]  i_id,
    output logic          o_ack,
    output logic          o_valid,
    output logic [DN-1:0] o_rdata,
    output logic [N-1:0]  o_rd_id,
    output logic [AN-1:0] o_sram_addr,
    output logic [DN-1:0] o_sram_dq_out,
    output logic          o_sram_dq_oe,
    input  logic [DN-1:0] i_sram_dq_in,
    output logic          o_sram_ce_n,
    output logic          o_sram_oe_n,
    output logic          o_sram_we_n
);

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    localparam logic [3:0] WAIT_CNT = WAIT[3:0];

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic          r_wr, w_wr_nxt;
    logic [N-1:0]  r_id, w_id_nxt;
    logic          r_ack, w_ack_nxt;
    logic          r_valid, w_valid_nxt;
    logic [DN-1:0] r_rdata, w_rdata_nxt;
    logic [N-1:0]  r_rd_id, w_rd_id_nxt;
    logic [AN-1:0] r_addr, w_addr_nxt;
    logic [DN-1:0] r_dq_out, w_dq_out_nxt;
    logic          r_dq_oe, w_dq_oe_nxt;
    logic          r_ce_n, w_ce_n_nxt;
    logic          r_oe_n, w_oe_n_nxt;
    logic          r_we_n, w_we_n_nxt;

    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_id     <= '0;
            r_ack    <= 1'b0;
            r_valid  <= 1'b0;
            r_rdata  <= '0;
            r_rd_id  <= '0;
            r_addr   <= '0;
            r_dq_out <= '0;
            r_dq_oe  <= 1'b0;
            r_ce_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_wr     <= w_wr_nxt;
            r_id     <= w_id_nxt;
            r_ack    <= w_ack_nxt;
            r_valid  <= w_valid_nxt;
            r_rdata  <= w_rdata_nxt;
            r_rd_id  <= w_rd_id_nxt;
            r_addr   <= w_addr_nxt;
            r_dq_out <= w_dq_out_nxt;
            r_dq_oe  <= w_dq_oe_nxt;
            r_ce_n   <= w_ce_n_nxt;
            r_oe_n   <= w_oe_n_nxt;
            r_we_n   <= w_we_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wr_nxt     = r_wr;
        w_id_nxt     = r_id;
        w_ack_nxt    = 1'b0;
        w_valid_nxt  = 1'b0;
        w_rdata_nxt  = r_rdata;
        w_rd_id_nxt  = r_rd_id;
        w_addr_nxt   = r_addr;
        w_dq_out_nxt = r_dq_out;
        w_dq_oe_nxt  = r_dq_oe;
        w_ce_n_nxt   = r_ce_n;
        w_oe_n_nxt   = r_oe_n;
        w_we_n_nxt   = r_we_n;
        case (r_state)
            IDLE: begin
                // The arbiter still holds req during the ack cycle; r_ack blocks a second accept.
                if (i_req && !r_ack) begin
                    w_wr_nxt    = i_wr;
                    w_id_nxt    = i_id;
                    w_addr_nxt  = i_addr;
                    w_ce_n_nxt  = 1'b0;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = WAIT_CNT;
                    w_state_nxt = ACCESS;
                    if (i_wr) begin
                        w_dq_out_nxt = i_wdata;
                        w_dq_oe_nxt  = 1'b1;
                        w_we_n_nxt   = 1'b0;
                        w_oe_n_nxt   = 1'b1;
                    end else begin
                        w_dq_oe_nxt  = 1'b0;
                        w_we_n_nxt   = 1'b1;
                        w_oe_n_nxt   = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (r_cnt == 4'd0) begin
                    if (r_wr) begin
                        // Data and address stay driven one more cycle for SRAM hold time.
                        w_we_n_nxt  = 1'b1;
                        w_state_nxt = RECOVER;
                    end else begin
                        w_rdata_nxt = i_sram_dq_in;
                        w_rd_id_nxt = r_id;
                        w_valid_nxt = 1'b1;
                        w_ce_n_nxt  = 1'b1;
                        w_oe_n_nxt  = 1'b1;
                        w_we_n_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RECOVER: begin
                w_dq_oe_nxt = 1'b0;
                w_ce_n_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_ack         = r_ack;
    assign o_valid       = r_valid;
    assign o_rdata       = r_rdata;
    assign o_rd_id       = r_rd_id;
    assign o_sram_addr   = r_addr;
    assign o_sram_dq_out = r_dq_out;
    assign o_sram_dq_oe  = r_dq_oe;
    assign o_sram_ce_n   = r_ce_n;
    assign o_sram_oe_n   = r_oe_n;
    assign o_sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_ctrl_sync.sv
// Bench for sram_ctrl_sync: timeline model of expected outputs per cycle plus directed literal checks.
module tb_sram_ctrl_sync;
    localparam int W    = 2;
    localparam int MAXC = 1024;

    logic        clkSYS = 1'b0;
    logic        n_reset;
    logic        i_req, i_wr;
    logic [15:0] i_addr;
    logic [7:0]  i_wdata;
    logic [1:0]  i_id;
    logic        o_ack, o_valid, o_sram_dq_oe, o_sram_ce_n, o_sram_oe_n, o_sram_we_n;
    logic [7:0]  o_rdata, o_sram_dq_out, sram_dq_in;
    logic [1:0]  o_rd_id;
    logic [15:0] o_sram_addr;

    logic        req0, wr0, ack0, valid0, dq_oe0, ce_n0, oe_n0, we_n0;
    logic [15:0] addr0, sram_addr0;
    logic [7:0]  wdata0, rdata0, dq_out0, dq_in0;
    logic [1:0]  id0, rd_id0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clkSYS = ~clkSYS;

    sram_ctrl_sync #(.AN(16), .DN(8), .N(2), .WAIT(W)) dut (
        .clkSYS(clkSYS), .n_reset(n_reset), .i_req(i_req), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_wr(i_wr), .i_id(i_id), .o_ack(o_ack), .o_valid(o_valid), .o_rdata(o_rdata),
        .o_rd_id(o_rd_id), .o_sram_addr(o_sram_addr), .o_sram_dq_out(o_sram_dq_out),
        .o_sram_dq_oe(o_sram_dq_oe), .i_sram_dq_in(sram_dq_in), .o_sram_ce_n(o_sram_ce_n),
        .o_sram_oe_n(o_sram_oe_n), .o_sram_we_n(o_sram_we_n));

    sram_ctrl_sync #(.AN(16), .DN(8), .N(2), .WAIT(0)) dut0 (
        .clkSYS(clkSYS), .n_reset(n_reset), .i_req(req0), .i_addr(addr0), .i_wdata(wdata0),
        .i_wr(wr0), .i_id(id0), .o_ack(ack0), .o_valid(valid0), .o_rdata(rdata0),
        .o_rd_id(rd_id0), .o_sram_addr(sram_addr0), .o_sram_dq_out(dq_out0),
        .o_sram_dq_oe(dq_oe0), .i_sram_dq_in(dq_in0), .o_sram_ce_n(ce_n0),
        .o_sram_oe_n(oe_n0), .o_sram_we_n(we_n0));

    // Asynchronous SRAM device models.
    bit [7:0] sram_mem [0:65535];
    assign sram_dq_in = sram_mem[o_sram_addr];
    assign dq_in0     = sram_addr0[7:0] ^ 8'h3C;
    always @(posedge clkSYS)
        if (n_reset && !o_sram_ce_n && !o_sram_we_n && o_sram_dq_oe)
            sram_mem[o_sram_addr] <= o_sram_dq_out;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference timeline: on acceptance at edge k the whole access is scheduled.
    bit [7:0]  ref_mem [0:65535];
    bit        e_ack [MAXC], e_valid [MAXC], e_ce [MAXC], e_oe [MAXC], e_we [MAXC], e_dqoe [MAXC];
    bit [15:0] e_addr [MAXC];
    bit [7:0]  e_wdat [MAXC], e_rdat [MAXC];
    bit [1:0]  e_rdid [MAXC];
    int        next_free = 0;

    always @(posedge clkSYS) begin
        int k;
        k   = cyc + 1;
        cyc = k;
        if (!n_reset) begin
            for (int c = k; c < MAXC; c++) begin
                e_ack[c] = 0; e_valid[c] = 0; e_ce[c] = 0; e_oe[c] = 0; e_we[c] = 0; e_dqoe[c] = 0;
            end
            next_free = 0;
        end else if (i_req && k >= next_free && !(k > 0 && e_ack[k-1]) && k + W + 3 < MAXC) begin
            e_ack[k] = 1;
            if (i_wr) begin
                for (int c = k; c <= k + W + 1; c++) begin
                    e_ce[c] = 1; e_dqoe[c] = 1; e_addr[c] = i_addr; e_wdat[c] = i_wdata;
                    e_we[c] = (c <= k + W);
                end
                ref_mem[i_addr] = i_wdata;
                next_free = k + W + 3;
            end else begin
                for (int c = k; c <= k + W; c++) begin
                    e_ce[c] = 1; e_oe[c] = 1; e_addr[c] = i_addr;
                end
                e_valid[k+W+1] = 1;
                e_rdat[k+W+1]  = ref_mem[i_addr];
                e_rdid[k+W+1]  = i_id;
                next_free = k + W + 2;
            end
        end
    end

    logic [7:0] m_rdata = 0;
    logic [1:0] m_rdid  = 0;
    always @(negedge clkSYS) begin
        if (!n_reset) begin
            m_rdata = 0; m_rdid = 0;
            chk("rst_ack", o_ack, 0);       chk("rst_valid", o_valid, 0);
            chk("rst_ce_n", o_sram_ce_n, 1); chk("rst_oe_n", o_sram_oe_n, 1);
            chk("rst_we_n", o_sram_we_n, 1); chk("rst_dq_oe", o_sram_dq_oe, 0);
            chk("rst_rdata", o_rdata, 0);    chk("rst_rd_id", o_rd_id, 0);
        end else if (cyc < MAXC) begin
            if (e_valid[cyc]) begin
                m_rdata = e_rdat[cyc]; m_rdid = e_rdid[cyc];
            end
            chk("ack", o_ack, e_ack[cyc]);
            chk("valid", o_valid, e_valid[cyc]);
            chk("ce_n", o_sram_ce_n, !e_ce[cyc]);
            chk("oe_n", o_sram_oe_n, !e_oe[cyc]);
            chk("we_n", o_sram_we_n, !e_we[cyc]);
            chk("dq_oe", o_sram_dq_oe, e_dqoe[cyc]);
            chk("rdata", o_rdata, m_rdata);
            chk("rd_id", o_rd_id, m_rdid);
            if (e_ce[cyc])   chk("sram_addr", o_sram_addr, e_addr[cyc]);
            if (e_dqoe[cyc]) chk("dq_out", o_sram_dq_out, e_wdat[cyc]);
            chk("oe_vs_dq_oe", o_sram_dq_oe && !o_sram_oe_n, 0);
            chk("oe_vs_we", !o_sram_we_n && !o_sram_oe_n, 0);
        end
    end

    // Event counters and read-response log for the directed checks.
    int n_we, n_oe, n_dqoe, n_valid, n_ack;
    logic [9:0] vq [$];
    always @(negedge clkSYS) begin
        if (n_reset) begin
            if (!o_sram_we_n) n_we++;
            if (!o_sram_oe_n) n_oe++;
            if (o_sram_dq_oe) n_dqoe++;
            if (o_ack) n_ack++;
            if (o_valid) begin
                n_valid++;
                vq.push_back({o_rd_id, o_rdata});
            end
        end
    end

    task automatic clear_cnt();
        n_we = 0; n_oe = 0; n_dqoe = 0; n_valid = 0; n_ack = 0;
        vq.delete();
    endtask

    task automatic wait_ack(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clkSYS); #1;
            if (o_ack) begin c = cyc; return; end
        end
        chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_valid(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clkSYS); #1;
            if (o_valid) begin c = cyc; return; end
        end
        chk("valid_timeout", 0, 1);
    endtask

    // Arbiter-style request: held through the ack cycle, dropped on the following edge.
    task automatic do_req(input logic [15:0] a, input logic [7:0] d, input logic w,
                          input logic [1:0] id, output int ac);
        i_req = 1; i_addr = a; i_wdata = d; i_wr = w; i_id = id;
        wait_ack(ac);
        @(posedge clkSYS); #1;
        i_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a2, a3, v, rel_cyc;
        sram_mem[16'h1234] = 8'hA5;
        ref_mem[16'h1234]  = 8'hA5;
        n_reset = 0;
        i_req = 1; i_addr = 16'h1234; i_wdata = 0; i_wr = 0; i_id = 2;
        req0 = 0; addr0 = 0; wdata0 = 0; wr0 = 0; id0 = 0;

        // Reset with req held, then read 0x1234.
        repeat (3) @(negedge clkSYS);
        #1;
        chk("lit_rst_ce_n", o_sram_ce_n, 1);
        chk("lit_rst_ack", o_ack, 0);
        clear_cnt();
        rel_cyc = cyc;
        n_reset = 1;
        wait_ack(a);
        chk("lit_first_ack_cycle", a, rel_cyc + 1);
        @(posedge clkSYS); #1;
        i_req = 0;
        wait_valid(v);
        chk("lit_rd_latency", v - a, 3);
        chk("lit_rd_data", o_rdata, 8'hA5);
        chk("lit_rd_id", o_rd_id, 2);
        chk("lit_oe_low_cycles", n_oe, 3);
        chk("lit_rd_ack_count", n_ack, 1);

        // Write 0x5A to 0x0010.
        repeat (2) @(posedge clkSYS);
        #1;
        clear_cnt();
        do_req(16'h0010, 8'h5A, 1'b1, 2'd1, a);
        repeat (6) @(posedge clkSYS);
        #1;
        chk("lit_we_low_cycles", n_we, 3);
        chk("lit_dq_oe_cycles", n_dqoe, 4);
        chk("lit_wr_no_valid", n_valid, 0);
        chk("lit_wr_ack_count", n_ack, 1);

        // Continuous requests: write, read back, read.
        clear_cnt();
        do_req(16'h0020, 8'h77, 1'b1, 2'd3, a1);
        do_req(16'h0010, 8'h00, 1'b0, 2'd1, a2);
        do_req(16'h0020, 8'h00, 1'b0, 2'd0, a3);
        repeat (6) @(posedge clkSYS);
        #1;
        chk("lit_wr_rd_gap", a2 - a1, 5);
        chk("lit_rd_rd_gap", a3 - a2, 4);
        chk("lit_b2b_ack_count", n_ack, 3);
        chk("lit_b2b_valid_count", vq.size(), 2);
        if (vq.size() >= 2) begin
            chk("lit_readback_0010", vq[0], {2'd1, 8'h5A});
            chk("lit_readback_0020", vq[1], {2'd0, 8'h77});
        end

        // Zero wait states on the second instance.
        req0 = 1; addr0 = 16'h00AB; id0 = 3; wr0 = 0;
        a = -1;
        for (int i = 0; i < 20 && a < 0; i++) begin
            @(posedge clkSYS); #1;
            if (ack0) a = cyc;
        end
        chk("lit_w0_ack_seen", a >= 0, 1);
        chk("lit_w0_no_valid_with_ack", valid0, 0);
        @(posedge clkSYS); #1;
        req0 = 0;
        chk("lit_w0_valid", valid0, 1);
        chk("lit_w0_rdata", rdata0, 8'h97);
        chk("lit_w0_rd_id", rd_id0, 3);
        chk("lit_w0_no_reack", ack0, 0);
        @(posedge clkSYS); #1;
        chk("lit_w0_valid_pulse", valid0, 0);
        chk("lit_w0_single_ack", ack0, 0);

        // Reset during a read access.
        do_req(16'h1234, 8'h00, 1'b0, 2'd3, a);
        n_reset = 0;
        #1;
        chk("lit_midrst_ce_n", o_sram_ce_n, 1);
        chk("lit_midrst_oe_n", o_sram_oe_n, 1);
        chk("lit_midrst_we_n", o_sram_we_n, 1);
        repeat (2) @(negedge clkSYS);
        #1;
        clear_cnt();
        n_reset = 1;
        repeat (6) @(posedge clkSYS);
        #1;
        chk("lit_midrst_no_valid", n_valid, 0);
        chk("lit_midrst_no_ack", n_ack, 0);
        do_req(16'h0010, 8'h00, 1'b0, 2'd2, a);
        repeat (4) @(posedge clkSYS);
        #1;
        chk("lit_post_rst_valid_count", vq.size(), 1);
        if (vq.size() >= 1) chk("lit_post_rst_read", vq[0], {2'd2, 8'h5A});

        repeat (2) @(posedge clkSYS);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
